// File: rtl/source_fade_switch.sv
// Click-free two-source stereo switch: ramps the live source to silence, swaps, ramps back.
// Optional macro SOURCE_FADE_SOFT_START_EN makes reset start silent and fade in.
module source_fade_switch #(
  parameter int WIDTH     = 24,
  parameter int RAMP_BITS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sel,
  input  logic [WIDTH-1:0]     dataInA_left,
  input  logic [WIDTH-1:0]     dataInA_right,
  input  logic [WIDTH-1:0]     dataInB_left,
  input  logic [WIDTH-1:0]     dataInB_right,
  output logic [WIDTH-1:0]     dataOut_left,
  output logic [WIDTH-1:0]     dataOut_right,
  output logic                 busy,
  output logic [1:0]           dbg_state,
  output logic [RAMP_BITS:0]   dbg_gain
);

  // Strobe semantics: en is a one-cycle sample strobe (read_ready & write_ready).
  // There is no back-pressure; every register holds its value on cycles with en=0.

  localparam int PW = WIDTH + RAMP_BITS + 2;
  localparam logic [RAMP_BITS:0] UNITY = {1'b1, {RAMP_BITS{1'b0}}};
  localparam logic [RAMP_BITS:0] ONE   = {{RAMP_BITS{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } state_t;

`ifdef SOURCE_FADE_SOFT_START_EN
  localparam state_t             RST_STATE = FADE_IN;
  localparam logic [RAMP_BITS:0] RST_GAIN  = '0;
`else
  localparam state_t             RST_STATE = IDLE;
  localparam logic [RAMP_BITS:0] RST_GAIN  = UNITY;
`endif

  state_t             state_q, state_d;
  logic [RAMP_BITS:0] gain_q, gain_d;
  logic               src_q, src_d;
  logic [WIDTH-1:0]   out_l_q, out_l_d;
  logic [WIDTH-1:0]   out_r_q, out_r_d;

  logic [WIDTH-1:0]     sample_l, sample_r;
  logic signed [PW-1:0] prod_l, prod_r;
  logic [RAMP_BITS:0]   gain_inc;
  logic                 unused_prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST_STATE;
      gain_q  <= RST_GAIN;
      src_q   <= 1'b0;
      out_l_q <= '0;
      out_r_q <= '0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      src_q   <= src_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
    end
  end

  assign gain_inc = gain_q + ONE;

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    src_d   = src_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (sel != src_q) state_d = FADE_OUT;
        end
        FADE_OUT: begin
          // A withdrawn request turns around at the current gain, no jump.
          if (sel == src_q) begin
            state_d = FADE_IN;
          end else if (gain_q == '0) begin
            src_d   = sel;
            state_d = FADE_IN;
          end else begin
            gain_d = gain_q - ONE;
          end
        end
        FADE_IN: begin
          if (sel != src_q) begin
            state_d = FADE_OUT;
          end else begin
            gain_d = gain_inc;
            if (gain_inc == UNITY) state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          gain_d  = UNITY;
        end
      endcase
    end
  end

  // Signed sample times unsigned gain, then floor-divide by unity via arithmetic shift.
  always_comb begin
    sample_l = src_q ? dataInB_left  : dataInA_left;
    sample_r = src_q ? dataInB_right : dataInA_right;
    prod_l   = PW'($signed(sample_l)) * PW'($signed({1'b0, gain_q}));
    prod_r   = PW'($signed(sample_r)) * PW'($signed({1'b0, gain_q}));
    out_l_d  = en ? prod_l[RAMP_BITS +: WIDTH] : out_l_q;
    out_r_d  = en ? prod_r[RAMP_BITS +: WIDTH] : out_r_q;
  end

  assign unused_prod = ^{prod_l[PW-1:WIDTH+RAMP_BITS], prod_l[RAMP_BITS-1:0],
                         prod_r[PW-1:WIDTH+RAMP_BITS], prod_r[RAMP_BITS-1:0]};

  always_comb begin
    busy          = (state_q != IDLE);
    dbg_state     = state_q;
    dbg_gain      = gain_q;
    dataOut_left  = out_l_q;
    dataOut_right = out_r_q;
  end

endmodule

// File: tb/tb_source_fade_switch.sv
// Randomized bench for source_fade_switch against a rule-level model of the fade switch.
module tb_source_fade_switch;

  localparam int UNITY = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        sel = 1'b0;
  logic [23:0] a_l = '0, a_r = '0, b_l = '0, b_r = '0;
  logic [23:0] dout_l, dout_r;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [6:0]  dbg_gain;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 = steady, 1 = ramping down, 2 = ramping up.
  int          m_phase, m_gain, m_src;
  logic [47:0] exp_q[$];
  logic [47:0] exp_v;

  source_fade_switch dut (
    .clk(clk), .reset(reset), .en(en), .sel(sel),
    .dataInA_left(a_l), .dataInA_right(a_r),
    .dataInB_left(b_l), .dataInB_right(b_r),
    .dataOut_left(dout_l), .dataOut_right(dout_r),
    .busy(busy), .dbg_state(dbg_state), .dbg_gain(dbg_gain)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] scale(input logic [23:0] s, input int g);
    longint p, q;
    logic [63:0] qv;
    p = longint'($signed(s)) * g;
    q = p / UNITY;
    if (p < 0 && (p % UNITY) != 0) q = q - 1;
    qv = q;
    return qv[23:0];
  endfunction

  task automatic model_reset();
`ifdef SOURCE_FADE_SOFT_START_EN
    m_phase = 2; m_gain = 0;
`else
    m_phase = 0; m_gain = UNITY;
`endif
    m_src = 0;
    exp_q.delete();
  endtask

  // One strobe with the given inputs; the model predicts from pre-edge gain/source.
  task automatic do_strobe(input bit s, input logic [23:0] al, ar, bl, br);
    @(negedge clk);
    en = 1'b1; sel = s; a_l = al; a_r = ar; b_l = bl; b_r = br;
    exp_q.push_back({scale(m_src ? bl : al, m_gain), scale(m_src ? br : ar, m_gain)});
    case (m_phase)
      0: if (int'(s) != m_src) m_phase = 1;
      1: begin
        if (int'(s) == m_src) m_phase = 2;
        else if (m_gain == 0) begin m_src = int'(s); m_phase = 2; end
        else m_gain = m_gain - 1;
      end
      default: begin
        if (int'(s) != m_src) m_phase = 1;
        else begin
          m_gain = m_gain + 1;
          if (m_gain == UNITY) m_phase = 0;
        end
      end
    endcase
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; en = 1'b1; sel = 1'b1;
    a_l = 24'h123456; b_l = 24'h654321;
    @(negedge clk);
    reset = 1'b0; en = 1'b0; sel = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dout_l !== 24'h0 || dout_r !== 24'h0) begin
      n_fail++; $display("FAIL reset_out: got %h/%h want 0/0", dout_l, dout_r);
    end
    n_checks++;
    if (busy !== (m_phase != 0)) begin
      n_fail++; $display("FAIL reset_busy: got %b want %b", busy, m_phase != 0);
    end
    n_checks++;
    if (dbg_gain !== 7'(m_gain)) begin
      n_fail++; $display("FAIL reset_gain: got %0d want %0d", dbg_gain, m_gain);
    end
  endtask

  task automatic settle();
    int k = 0;
    while (m_phase != 0 && k < 200) begin
      do_strobe(m_src[0], 24'h000100, 24'hFFFF00, 24'h000200, 24'hFFFE00);
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({dout_l, dout_r} !== exp_v) begin
        n_fail++; $display("FAIL settle_out: got %h want %h", {dout_l, dout_r}, exp_v);
      end
      k++;
    end
  endtask

  task automatic test_steady();
    do_reset(); settle();
    for (int i = 0; i < 10; i++) begin
      do_strobe(1'b0, 24'h100000, 24'h100000, 24'h200000, 24'h200000);
      void'(exp_q.pop_front());
      n_checks++;
      if (dout_l !== 24'h100000 || dout_r !== 24'h100000 || busy !== 1'b0) begin
        n_fail++; $display("FAIL steady: got %h/%h busy %b want 100000 busy 0", dout_l, dout_r, busy);
      end
    end
  endtask

  task automatic test_full_switch();
    int k = 0;
    int pre_gain, pre_src;
    bit done = 0;
    while (!done && k < 200) begin
      pre_gain = m_gain; pre_src = m_src;
      do_strobe(1'b1, 24'h100000, 24'h100000, 24'hF00000, 24'hF00000);
      k++;
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({dout_l, dout_r} !== exp_v || dbg_gain !== 7'(m_gain) || busy !== (m_phase != 0)) begin
        n_fail++; $display("FAIL switch_step%0d: got %h g%0d b%b want %h g%0d", k, {dout_l, dout_r}, dbg_gain, busy, exp_v, m_gain);
      end
      if (pre_gain == 32 && pre_src == 0) begin
        n_checks++;
        if (dout_l !== 24'h080000) begin
          n_fail++; $display("FAIL switch_half: got %h want 080000", dout_l);
        end
      end
      done = (busy == 1'b0);
    end
    n_checks++;
    if (k != 130) begin
      n_fail++; $display("FAIL switch_len: got %0d strobes want 130", k);
    end
    do_strobe(1'b1, 24'h100000, 24'h100000, 24'hF00000, 24'hF00000);
    void'(exp_q.pop_front());
    n_checks++;
    if (dout_l !== 24'hF00000 || dout_r !== 24'hF00000) begin
      n_fail++; $display("FAIL switch_final: got %h/%h want F00000", dout_l, dout_r);
    end
  endtask

  task automatic test_abort();
    int k = 0;
    do_reset(); settle();
    while (!(m_phase == 1 && m_gain == 40) && k < 100) begin
      do_strobe(1'b1, 24'h100000, 24'h0ABCDE, 24'hF00000, 24'hF11111);
      void'(exp_q.pop_front());
      k++;
    end
    n_checks++;
    if (dbg_gain !== 7'd40) begin
      n_fail++; $display("FAIL abort_start_gain: got %0d want 40", dbg_gain);
    end
    do_strobe(1'b0, 24'h100000, 24'h0ABCDE, 24'hF00000, 24'hF11111);
    void'(exp_q.pop_front());
    n_checks++;
    if (dbg_gain !== 7'd40 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_turn: got g%0d b%b want g40 b1", dbg_gain, busy);
    end
    k = 0;
    while (busy && k < 100) begin
      do_strobe(1'b0, 24'h100000, 24'h0ABCDE, 24'hF00000, 24'hF11111);
      exp_v = exp_q.pop_front();
      k++;
      n_checks++;
      if ({dout_l, dout_r} !== exp_v || dout_l[23] !== 1'b0 || dbg_gain !== 7'(40 + k)) begin
        n_fail++; $display("FAIL abort_ramp%0d: got %h g%0d want %h g%0d", k, {dout_l, dout_r}, dbg_gain, exp_v, 40 + k);
      end
    end
    n_checks++;
    if (k != 24) begin
      n_fail++; $display("FAIL abort_len: got %0d want 24", k);
    end
  endtask

  task automatic test_neg_rounding();
    int k = 0;
    do_reset(); settle();
    while (!(m_phase == 1 && m_gain == 32) && k < 100) begin
      do_strobe(1'b1, 24'h000400, 24'h000400, 24'h000800, 24'h000800);
      void'(exp_q.pop_front());
      k++;
    end
    do_strobe(1'b1, 24'hFFFFFF, 24'hFFFFC1, 24'h0, 24'h0);
    void'(exp_q.pop_front());
    n_checks++;
    if (dout_l !== 24'hFFFFFF || dout_r !== 24'hFFFFE0) begin
      n_fail++; $display("FAIL neg_round: got %h/%h want FFFFFF/FFFFE0", dout_l, dout_r);
    end
    for (int i = 0; i < 40; i++) begin
      do_strobe(1'b1, 24'($urandom_range(24'h800000, 24'hFFFFFF)), 24'($urandom),
                24'($urandom), 24'($urandom));
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({dout_l, dout_r} !== exp_v) begin
        n_fail++; $display("FAIL neg_rand%0d: got %h want %h", i, {dout_l, dout_r}, exp_v);
      end
    end
  endtask

  task automatic test_no_strobe();
    logic [23:0] hold_l, hold_r;
    for (int i = 0; i < 5; i++) begin
      do_strobe(~m_src[0], 24'h300000, 24'h200000, 24'hC00000, 24'hD00000);
      void'(exp_q.pop_front());
    end
    hold_l = scale(24'h0, 0);
    hold_l = dout_l; hold_r = dout_r;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      sel = 1'($urandom); a_l = 24'($urandom); b_l = 24'($urandom);
      a_r = 24'($urandom); b_r = 24'($urandom);
    end
    n_checks++;
    if (dout_l !== hold_l || dout_r !== hold_r || dbg_gain !== 7'(m_gain) || busy !== (m_phase != 0)) begin
      n_fail++; $display("FAIL no_strobe: got %h/%h g%0d want %h/%h g%0d", dout_l, dout_r, dbg_gain, hold_l, hold_r, m_gain);
    end
  endtask

  task automatic test_random();
    bit s = 1'b0;
    do_reset(); settle();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) s = ~s;
      do_strobe(s, 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
      exp_v = exp_q.pop_front();
      n_checks++;
      if ({dout_l, dout_r} !== exp_v || dbg_gain !== 7'(m_gain) || busy !== (m_phase != 0)) begin
        n_fail++; $display("FAIL rand%0d: got %h g%0d b%b want %h g%0d b%b", i, {dout_l, dout_r}, dbg_gain, busy, exp_v, m_gain, m_phase != 0);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int k = 0;
    do_reset(); settle();
    while (!(m_phase == 1 && m_gain == 20) && k < 100) begin
      do_strobe(1'b1, 24'h100000, 24'h100000, 24'hF00000, 24'hF00000);
      void'(exp_q.pop_front());
      k++;
    end
    do_reset();
    n_checks++;
`ifdef SOURCE_FADE_SOFT_START_EN
    if (dout_l !== 24'h0 || dbg_gain !== 7'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: got %h g%0d b%b want 0 g0 b1", dout_l, dbg_gain, busy);
    end
`else
    if (dout_l !== 24'h0 || dbg_gain !== 7'd64 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got %h g%0d b%b want 0 g64 b0", dout_l, dbg_gain, busy);
    end
`endif
    k = 0;
    while (busy && k < 100) begin
      do_strobe(1'b0, 24'h100000, 24'h100000, 24'hF00000, 24'hF00000);
      void'(exp_q.pop_front());
      k++;
    end
`ifdef SOURCE_FADE_SOFT_START_EN
    n_checks++;
    if (k != 64) begin
      n_fail++; $display("FAIL soft_start_len: got %0d want 64", k);
    end
`endif
    do_strobe(1'b0, 24'h100000, 24'h100000, 24'hF00000, 24'hF00000);
    void'(exp_q.pop_front());
    n_checks++;
    if (dout_l !== 24'h100000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_pass: got %h b%b want 100000 b0", dout_l, busy);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_steady();
    test_full_switch();
    test_abort();
    test_neg_rounding();
    test_no_strobe();
    test_random();
    test_reset_mid_ramp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
